// File: rtl/icache_rvc_assoc_if.sv
// Fetch-port and line-fill bus of the RVC instruction cache.
// The cache is the slave side; the pipeline/memory environment is the master side.
interface icache_rvc_assoc_if;
  logic         proc_read;
  logic [30:0]  proc_addr;
  logic [31:0]  proc_rdata;
  logic         proc_stall;
  logic         proc_pcadd;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ready;

  modport slave (
    input  proc_read, proc_addr, mem_rdata, mem_ready,
    output proc_rdata, proc_stall, proc_pcadd, mem_read, mem_write, mem_addr, mem_wdata
  );

  modport master (
    output proc_read, proc_addr, mem_rdata, mem_ready,
    input  proc_rdata, proc_stall, proc_pcadd, mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/icache_rvc_assoc.sv
// Read-only 1/2-way instruction cache with 128-bit lines; returns a 32-bit fetch word from any
// halfword offset, filling up to two lines when a 32-bit instruction straddles a line boundary.
module icache_rvc_assoc #(
  parameter int unsigned SET_BITS = 3,
  parameter int unsigned TWO_WAY  = 1
) (
  input logic               clk,
  input logic               proc_reset,
  icache_rvc_assoc_if.slave bus
);

  localparam int unsigned NumWays = (TWO_WAY != 0) ? 2 : 1;
  localparam int unsigned NumSets = 1 << SET_BITS;
  localparam int unsigned TagW    = 28 - SET_BITS;

  typedef enum logic {StIdle, StFill} state_e;

  state_e state_q, state_d;

  logic [127:0]       data_q  [NumWays][NumSets];
  logic [TagW-1:0]    tag_q   [NumWays][NumSets];
  logic [NumSets-1:0] valid_q [NumWays];

  logic [27:0]         line_a, line_b;
  logic [SET_BITS-1:0] set_a, set_b;
  logic [TagW-1:0]     tag_a, tag_b;
  logic [2:0]          half, half_n;

  logic [NumWays-1:0] hit_a, hit_b;
  logic               hit_any_a, hit_any_b;
  logic [127:0]       a_data;
  logic [15:0]        b_half0;
  logic [15:0]        first_half, next_half;
  logic               full, need_b, resident;

  logic [27:0]         fill_line_q, fill_line_d;
  logic                mem_read_q, mem_read_d;
  logic                install;
  logic [SET_BITS-1:0] fill_set;
  logic [TagW-1:0]     fill_tag;
  logic                lru_fill;
  logic                victim_way;
  logic [NumWays-1:0]  victim;

  // Address decode for the line holding the fetch and its successor (28-bit wrap).
  assign line_a = bus.proc_addr[30:3];
  assign line_b = line_a + 28'd1;
  assign half   = bus.proc_addr[2:0];
  assign half_n = half + 3'd1;
  assign set_a  = line_a[SET_BITS-1:0];
  assign tag_a  = line_a[27:SET_BITS];
  assign set_b  = line_b[SET_BITS-1:0];
  assign tag_b  = line_b[27:SET_BITS];

  always_comb begin
    hit_a   = '0;
    hit_b   = '0;
    a_data  = '0;
    b_half0 = '0;
    for (int w = 0; w < int'(NumWays); w++) begin
      hit_a[w] = valid_q[w][set_a] && (tag_q[w][set_a] == tag_a);
      hit_b[w] = valid_q[w][set_b] && (tag_q[w][set_b] == tag_b);
      if (hit_a[w]) a_data = data_q[w][set_a];
      if (hit_b[w]) b_half0 = data_q[w][set_b][15:0];
    end
  end

  assign hit_any_a = |hit_a;
  assign hit_any_b = |hit_b;

  // a_data is zero on an LA miss, so the compressed/straddle decision only means
  // something once LA is resident.
  assign first_half = a_data[{half, 4'b0000} +: 16];
  assign full       = (first_half[1:0] == 2'b11);
  assign need_b     = (half == 3'd7) && full;
  assign next_half  = (half == 3'd7) ? b_half0 : a_data[{half_n, 4'b0000} +: 16];
  assign resident   = hit_any_a && !(need_b && !hit_any_b);

  assign bus.proc_stall = bus.proc_read && !resident;
  assign bus.proc_pcadd = resident && full;
  assign bus.proc_rdata = !resident ? 32'h0 :
                          full      ? {next_half, first_half} : {16'h0, first_half};

  assign bus.mem_read  = mem_read_q;
  assign bus.mem_addr  = fill_line_q;
  assign bus.mem_write = 1'b0;
  assign bus.mem_wdata = '0;

  always_comb begin
    state_d     = state_q;
    fill_line_d = fill_line_q;
    mem_read_d  = mem_read_q;
    install     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.proc_read && !resident) begin
          state_d     = StFill;
          mem_read_d  = 1'b1;
          fill_line_d = hit_any_a ? line_b : line_a;
        end
      end
      StFill: begin
        if (bus.mem_ready) begin
          install    = 1'b1;
          mem_read_d = 1'b0;
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign fill_set = fill_line_q[SET_BITS-1:0];
  assign fill_tag = fill_line_q[27:SET_BITS];

  // Lowest-numbered invalid way wins; otherwise replace the LRU way.
  always_comb begin
    victim_way = lru_fill;
    for (int w = int'(NumWays) - 1; w >= 0; w--) begin
      if (!valid_q[w][fill_set]) victim_way = w[0];
    end
    victim = '0;
    for (int w = 0; w < int'(NumWays); w++) begin
      victim[w] = (w[0] == victim_way);
    end
  end

  always_ff @(posedge clk) begin
    if (proc_reset) begin
      state_q     <= StIdle;
      mem_read_q  <= 1'b0;
      fill_line_q <= '0;
      for (int w = 0; w < int'(NumWays); w++) valid_q[w] <= '0;
    end else begin
      state_q     <= state_d;
      mem_read_q  <= mem_read_d;
      fill_line_q <= fill_line_d;
      if (install) begin
        for (int w = 0; w < int'(NumWays); w++) begin
          if (victim[w]) valid_q[w][fill_set] <= 1'b1;
        end
      end
    end
  end

  // Payload arrays need no reset: a line is only visible through its valid bit.
  always_ff @(posedge clk) begin
    if (install) begin
      for (int w = 0; w < int'(NumWays); w++) begin
        if (victim[w]) begin
          data_q[w][fill_set] <= bus.mem_rdata;
          tag_q[w][fill_set]  <= fill_tag;
        end
      end
    end
  end

  if (TWO_WAY != 0) begin : g_lru
    logic [NumSets-1:0] lru_q;  // way to replace next in each set
    logic               touch_a, touch_b;

    assign touch_a  = bus.proc_read && hit_any_a;
    assign touch_b  = bus.proc_read && hit_any_a && need_b && hit_any_b;
    assign lru_fill = lru_q[fill_set];

    always_ff @(posedge clk) begin
      if (proc_reset) begin
        lru_q <= '0;
      end else begin
        if (touch_a) lru_q[set_a] <= hit_a[0];
        if (touch_b) lru_q[set_b] <= hit_b[0];
        if (install) lru_q[fill_set] <= victim[0];
      end
    end
  end else begin : g_no_lru
    assign lru_fill = 1'b0;
  end

endmodule

// File: tb/tb_icache_rvc_assoc.sv
// Randomised and directed bench for icache_rvc_assoc: one 2-way and one direct-mapped instance,
// a latency-programmable line memory and a recency-list model of cache residency.
module tb_icache_rvc_assoc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         proc_reset = 1'b1;
  logic         proc_read  = 1'b0;
  logic [30:0]  proc_addr  = '0;
  logic         mem_ready  = 1'b0;
  logic [127:0] mem_rdata  = '0;
  logic         dm_sel     = 1'b0;

  icache_rvc_assoc_if a_if ();
  icache_rvc_assoc_if d_if ();

  assign a_if.proc_read = proc_read & ~dm_sel;
  assign d_if.proc_read = proc_read & dm_sel;
  assign a_if.proc_addr = proc_addr;
  assign d_if.proc_addr = proc_addr;
  assign a_if.mem_ready = mem_ready;
  assign d_if.mem_ready = mem_ready;
  assign a_if.mem_rdata = mem_rdata;
  assign d_if.mem_rdata = mem_rdata;

  icache_rvc_assoc #(.SET_BITS(3), .TWO_WAY(1)) dut_a (
    .clk(clk), .proc_reset(proc_reset), .bus(a_if.slave)
  );
  icache_rvc_assoc #(.SET_BITS(3), .TWO_WAY(0)) dut_d (
    .clk(clk), .proc_reset(proc_reset), .bus(d_if.slave)
  );

  logic        cur_stall, cur_pcadd, cur_mem_read, cur_mem_write;
  logic [31:0] cur_rdata;
  logic [27:0] cur_mem_addr;
  assign cur_stall     = dm_sel ? d_if.proc_stall : a_if.proc_stall;
  assign cur_pcadd     = dm_sel ? d_if.proc_pcadd : a_if.proc_pcadd;
  assign cur_rdata     = dm_sel ? d_if.proc_rdata : a_if.proc_rdata;
  assign cur_mem_read  = dm_sel ? d_if.mem_read : a_if.mem_read;
  assign cur_mem_write = dm_sel ? d_if.mem_write : a_if.mem_write;
  assign cur_mem_addr  = dm_sel ? d_if.mem_addr : a_if.mem_addr;

  int checks = 0;
  int errors = 0;

  // ---------------- backing memory ----------------
  logic [127:0] ovr [logic [27:0]];

  function automatic logic [127:0] hash_line(input logic [27:0] la);
    logic [127:0] r;
    logic [31:0]  x;
    for (int i = 0; i < 8; i++) begin
      x = ({4'h0, la} + 32'(i) * 32'h0001_0003) * 32'h9E37_79B1;
      r[i*16 +: 16] = x[31:16] ^ x[15:0];
    end
    return r;
  endfunction

  function automatic logic [127:0] line_of(input logic [27:0] la);
    if (ovr.exists(la)) return ovr[la];
    return hash_line(la);
  endfunction

  function automatic void set_half(input logic [27:0] la, input int h, input logic [15:0] v);
    logic [127:0] t;
    t = ovr.exists(la) ? ovr[la] : hash_line(la);
    t[h*16 +: 16] = v;
    ovr[la] = t;
  endfunction

  // ---------------- memory responder ----------------
  int          lat = 1;
  int          cnt = 0;
  bit          busy = 1'b0;
  bit          write_seen = 1'b0;
  logic [27:0] fill_q [$];

  initial begin
    forever begin
      @(negedge clk);
      if (a_if.mem_write || d_if.mem_write) write_seen = 1'b1;
      if (mem_ready) begin
        mem_ready = 1'b0;
      end else if (cur_mem_read) begin
        if (!busy) begin
          busy = 1'b1;
          cnt  = 0;
          fill_q.push_back(cur_mem_addr);
        end
        cnt++;
        if (cnt == lat + 1) begin
          mem_ready = 1'b1;
          mem_rdata = line_of(cur_mem_addr);
          busy      = 1'b0;
        end
      end else begin
        busy = 1'b0;
      end
    end
  end

  // ---------------- reference model: per-set recency lists ----------------
  int          ways = 2;
  logic [27:0] res_line [8][2];
  int          res_cnt  [8];

  int          exp_cycles, obs_cycles;
  logic [31:0] exp_rdata, obs_rdata;
  logic        exp_pcadd, obs_pcadd;
  logic [57:0] exp_fills, obs_fills;

  function automatic void model_reset();
    for (int s = 0; s < 8; s++) res_cnt[s] = 0;
  endfunction

  function automatic bit is_resident(input logic [27:0] l);
    int s = int'(l[2:0]);
    for (int i = 0; i < res_cnt[s]; i++) if (res_line[s][i] == l) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void touch(input logic [27:0] l);
    int s = int'(l[2:0]);
    if (res_cnt[s] == 2 && res_line[s][1] == l) begin
      res_line[s][1] = res_line[s][0];
      res_line[s][0] = l;
    end
  endfunction

  function automatic void insert(input logic [27:0] l);
    int s = int'(l[2:0]);
    if (ways == 2) res_line[s][1] = res_line[s][0];
    res_line[s][0] = l;
    if (res_cnt[s] < ways) res_cnt[s]++;
  endfunction

  function automatic void predict(input logic [30:0] a, input int l);
    logic [27:0]  la, lb, f0, f1;
    logic [127:0] ln;
    logic [15:0]  first, second;
    int           h, n;
    la = a[30:3]; h = int'(a[2:0]); n = 0; f0 = '0; f1 = '0;
    if (!is_resident(la)) begin f0 = la; n = 1; insert(la); end
    ln = line_of(la);
    first = ln[h*16 +: 16];
    second = 16'h0;
    if (first[1:0] == 2'b11) begin
      if (h == 7) begin
        lb = la + 28'd1;
        if (!is_resident(lb)) begin
          if (n == 0) f0 = lb; else f1 = lb;
          n++;
          insert(lb);
        end
        touch(lb);
        ln = line_of(lb);
        second = ln[15:0];
      end else begin
        second = ln[(h+1)*16 +: 16];
      end
    end
    touch(la);
    exp_pcadd  = (first[1:0] == 2'b11);
    exp_rdata  = exp_pcadd ? {second, first} : {16'h0, first};
    exp_fills  = {2'(n), f0, f1};
    exp_cycles = n * (l + 2);
  endfunction

  // ---------------- stimulus ----------------
  task automatic do_reset();
    @(negedge clk);
    proc_read  = 1'b0;
    proc_reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    proc_reset = 1'b0;
    model_reset();
  endtask

  task automatic fetch(input logic [30:0] a, input int l);
    int n;
    lat = l;
    fill_q.delete();
    @(negedge clk);
    proc_addr = a;
    proc_read = 1'b1;
    #1;
    n = 0;
    while (cur_stall && n < 400) begin
      @(negedge clk);
      #1;
      n++;
    end
    obs_cycles = cur_stall ? -1 : n;
    obs_rdata  = cur_rdata;
    obs_pcadd  = cur_pcadd;
    obs_fills  = {2'(fill_q.size() > 3 ? 3 : fill_q.size()),
                  (fill_q.size() > 0) ? fill_q[0] : 28'h0,
                  (fill_q.size() > 1) ? fill_q[1] : 28'h0};
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (cur_mem_read !== 1'b0) begin errors++; $display("FAIL reset mem_read got %b want 0", cur_mem_read); end
    checks++; if (cur_mem_addr !== 28'h0) begin errors++; $display("FAIL reset mem_addr got %h want 0", cur_mem_addr); end
    checks++; if (cur_stall !== 1'b0) begin errors++; $display("FAIL reset stall got %b want 0", cur_stall); end
    checks++; if (cur_rdata !== 32'h0) begin errors++; $display("FAIL reset rdata got %h want 0", cur_rdata); end
    checks++; if (cur_mem_write !== 1'b0) begin errors++; $display("FAIL reset mem_write got %b want 0", cur_mem_write); end
  endtask

  task automatic test_idle();
    @(negedge clk);
    proc_read = 1'b0;
    proc_addr = {28'h0000077, 3'd2};
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (cur_stall !== 1'b0 || cur_mem_read !== 1'b0) begin
        errors++; $display("FAIL idle stall/mem_read got %b/%b want 0/0", cur_stall, cur_mem_read);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_cold_miss();
    predict(31'h0000010, 4);
    fetch(31'h0000010, 4);
    checks++; if (obs_cycles !== 6) begin errors++; $display("FAIL cold stall_cycles got %0d want 6", obs_cycles); end
    checks++; if (obs_fills !== {2'd1, 28'h2, 28'h0}) begin errors++; $display("FAIL cold fills got %h want %h", obs_fills, {2'd1, 28'h2, 28'h0}); end
    checks++; if (obs_rdata !== 32'hABCD_1237) begin errors++; $display("FAIL cold rdata got %h want abcd1237", obs_rdata); end
    checks++; if (obs_pcadd !== 1'b1) begin errors++; $display("FAIL cold pcadd got %b want 1", obs_pcadd); end
    predict(31'h0000010, 4);
    fetch(31'h0000010, 4);
    checks++; if (obs_cycles !== 0) begin errors++; $display("FAIL hit stall_cycles got %0d want 0", obs_cycles); end
  endtask

  task automatic test_compressed();
    logic [30:0] addr [2];
    logic [31:0] want [2];
    addr[0] = {28'h20, 3'd3}; want[0] = 32'h0000_4501;
    addr[1] = {28'h21, 3'd3}; want[1] = 32'hBEEF_0513;
    for (int i = 0; i < 2; i++) begin
      predict(addr[i], 2);
      fetch(addr[i], 2);
      checks++; if (obs_rdata !== want[i]) begin errors++; $display("FAIL rvc rdata[%0d] got %h want %h", i, obs_rdata, want[i]); end
      checks++; if (obs_pcadd !== 1'(i)) begin errors++; $display("FAIL rvc pcadd[%0d] got %b want %0d", i, obs_pcadd, i); end
      checks++; if (obs_cycles !== 4) begin errors++; $display("FAIL rvc stall_cycles[%0d] got %0d want 4", i, obs_cycles); end
    end
  endtask

  task automatic test_straddle(input logic [27:0] la, input logic [31:0] want, input string nm);
    do_reset();
    predict({la, 3'd7}, 3);
    fetch({la, 3'd7}, 3);
    checks++; if (obs_fills !== {2'd2, la, la + 28'd1}) begin errors++; $display("FAIL %s fills got %h want %h", nm, obs_fills, {2'd2, la, la + 28'd1}); end
    checks++; if (obs_cycles !== 10) begin errors++; $display("FAIL %s stall_cycles got %0d want 10", nm, obs_cycles); end
    checks++; if (obs_rdata !== want) begin errors++; $display("FAIL %s rdata got %h want %h", nm, obs_rdata, want); end
    checks++; if (obs_pcadd !== 1'b1) begin errors++; $display("FAIL %s pcadd got %b want 1", nm, obs_pcadd); end
  endtask

  task automatic test_lru();
    logic [27:0] seq [6];
    int          want [6];
    seq = '{28'h40, 28'h48, 28'h40, 28'h50, 28'h40, 28'h48};
    want = '{4, 4, 0, 4, 0, 4};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      predict({seq[i], 3'd0}, 2);
      fetch({seq[i], 3'd0}, 2);
      checks++; if (obs_cycles !== want[i]) begin errors++; $display("FAIL lru stall_cycles[%0d] line %h got %0d want %0d", i, seq[i], obs_cycles, want[i]); end
      checks++; if (obs_rdata !== exp_rdata) begin errors++; $display("FAIL lru rdata[%0d] got %h want %h", i, obs_rdata, exp_rdata); end
    end
  endtask

  task automatic test_reset_mid_fill();
    logic [27:0] la;
    int          n;
    la = 28'h0000123;
    do_reset();
    lat = 20;
    fill_q.delete();
    @(negedge clk);
    proc_addr = {la, 3'd1};
    proc_read = 1'b1;
    #1;
    n = 0;
    while (!cur_mem_read && n < 10) begin @(negedge clk); #1; n++; end
    checks++; if (cur_mem_read !== 1'b1 || cur_mem_addr !== la) begin
      errors++; $display("FAIL abort fill_start got %b/%h want 1/%h", cur_mem_read, cur_mem_addr, la);
    end
    @(negedge clk);
    proc_reset = 1'b1;
    proc_read  = 1'b0;
    @(negedge clk);
    #1;
    checks++; if (cur_mem_read !== 1'b0) begin errors++; $display("FAIL abort mem_read got %b want 0", cur_mem_read); end
    proc_reset = 1'b0;
    model_reset();
    predict({la, 3'd1}, 2);
    fetch({la, 3'd1}, 2);
    checks++; if (obs_fills !== {2'd1, la, 28'h0}) begin errors++; $display("FAIL abort refill got %h want %h", obs_fills, {2'd1, la, 28'h0}); end
    checks++; if (obs_cycles !== 4) begin errors++; $display("FAIL abort stall_cycles got %0d want 4", obs_cycles); end
  endtask

  task automatic test_random(input int iters, input string nm);
    logic [27:0] la;
    logic [30:0] a;
    int          l;
    do_reset();
    for (int i = 0; i < iters; i++) begin
      la = ($urandom_range(0, 4) == 0) ? 28'hFFFFFFC + 28'($urandom_range(0, 3))
                                       : 28'($urandom_range(0, 23));
      a  = {la, 3'($urandom_range(0, 7))};
      l  = $urandom_range(1, 4);
      if ($urandom_range(0, 5) == 0) begin @(negedge clk); proc_read = 1'b0; end
      predict(a, l);
      fetch(a, l);
      checks++; if (obs_cycles !== exp_cycles) begin errors++; $display("FAIL %s stall_cycles addr=%h got %0d want %0d", nm, a, obs_cycles, exp_cycles); end
      checks++; if (obs_fills !== exp_fills) begin errors++; $display("FAIL %s fills addr=%h got %h want %h", nm, a, obs_fills, exp_fills); end
      checks++; if (obs_rdata !== exp_rdata) begin errors++; $display("FAIL %s rdata addr=%h got %h want %h", nm, a, obs_rdata, exp_rdata); end
      checks++; if (obs_pcadd !== exp_pcadd) begin errors++; $display("FAIL %s pcadd addr=%h got %b want %b", nm, a, obs_pcadd, exp_pcadd); end
    end
  endtask

  task automatic test_direct_mapped();
    logic [27:0] la;
    dm_sel = 1'b1;
    ways   = 1;
    do_reset();
    write_seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      la = (i % 2 == 0) ? 28'h00 : 28'h08;
      predict({la, 3'd0}, 1);
      fetch({la, 3'd0}, 1);
      checks++; if (obs_cycles !== 3) begin errors++; $display("FAIL dm stall_cycles[%0d] got %0d want 3", i, obs_cycles); end
      checks++; if (obs_fills !== {2'd1, la, 28'h0}) begin errors++; $display("FAIL dm fills[%0d] got %h want %h", i, obs_fills, {2'd1, la, 28'h0}); end
    end
    test_random(60, "dm_rand");
    checks++; if (write_seen !== 1'b0) begin errors++; $display("FAIL dm mem_write got %b want 0", write_seen); end
  endtask

  initial begin
    set_half(28'h2, 0, 16'h1237);
    set_half(28'h2, 1, 16'hABCD);
    set_half(28'h20, 3, 16'h4501);
    set_half(28'h21, 3, 16'h0513);
    set_half(28'h21, 4, 16'hBEEF);
    set_half(28'h30, 7, 16'h00B3);
    set_half(28'h31, 0, 16'h2222);
    set_half(28'hFFFFFFF, 7, 16'h00B3);
    set_half(28'h0, 0, 16'h1111);

    test_reset();
    test_idle();
    test_cold_miss();
    test_compressed();
    test_straddle(28'h30, 32'h2222_00B3, "straddle");
    test_straddle(28'hFFFFFFF, 32'h1111_00B3, "wrap");
    test_lru();
    test_reset_mid_fill();
    test_random(150, "rand");
    test_direct_mapped();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
